// File: rtl/dmem_arbiter_pkg.sv
// Shared types and AHB-Lite encodings for the data-memory arbiter slice.
package srv_defs;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        write;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    // One-hot grant to port index; gnt is never 2'b11.
    function automatic port_e gnt_to_port(input logic [1:0] gnt);
        return gnt[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin on contention, or port 0 always wins when FIXED_PRIO=1.
module rr_arb2
    import srv_defs::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    port_e last_grant_q;

    always_comb begin
        gnt = '0;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    if (FIXED_PRIO)
                        gnt = 2'b01;
                    else
                        gnt = (last_grant_q == PORT0) ? 2'b10 : 2'b01;
                end
                default: gnt = '0;
            endcase
        end
    end

    // Reset to PORT1 so the first contention after reset goes to port 0.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= PORT1;
        else if (|gnt)
            last_grant_q <= gnt_to_port(gnt);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one AHB-Lite data-memory master port between two load/store requesters,
// pipelining address and data phases so back-to-back transfers run at full rate.
module dmem_arbiter
    import srv_defs::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [1:0]  req0_size,
    input  logic        req0_write,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,
    output logic        resp0_err,

    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [1:0]  req1_size,
    input  logic        req1_write,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,
    output logic        resp1_err,

    output logic [31:0] dmem_haddr,
    output logic [2:0]  dmem_hburst,
    output logic        dmem_hmastlock,
    output logic [3:0]  dmem_hprot,
    output logic [2:0]  dmem_hsize,
    output logic [1:0]  dmem_htrans,
    output logic [31:0] dmem_hwdata,
    output logic        dmem_hwrite,
    input  logic [31:0] dmem_hrdata,
    input  logic        dmem_hready,
    input  logic        dmem_hresp
);

    logic        a_valid_q;
    port_e       a_owner_q;
    dmem_req_t   a_req_q;

    logic        d_valid_q;
    port_e       d_owner_q;
    logic        d_write_q;
    logic [31:0] d_wdata_q;

    logic        a_free;
    logic [1:0]  gnt;
    dmem_req_t   req0, req1, sel_req;
    logic        done;

    assign req0 = '{addr: req0_addr, size: req0_size, write: req0_write, wdata: req0_wdata};
    assign req1 = '{addr: req1_addr, size: req1_size, write: req1_write, wdata: req1_wdata};
    assign sel_req = gnt[1] ? req1 : req0;

    assign a_free = !a_valid_q || dmem_hready;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req ({req1_valid, req0_valid}),
        .en  (a_free && !rst),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    // Data fields carry no reset; the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            if (dmem_hready) begin
                d_valid_q <= a_valid_q;
                d_owner_q <= a_owner_q;
                d_write_q <= a_req_q.write;
                d_wdata_q <= a_req_q.wdata;
            end
            if (a_free) begin
                a_valid_q <= |gnt;
                if (|gnt) begin
                    a_owner_q <= gnt_to_port(gnt);
                    a_req_q   <= sel_req;
                end
            end
        end
    end

    assign dmem_htrans    = (a_valid_q && !rst) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign dmem_haddr     = a_req_q.addr;
    assign dmem_hsize     = {1'b0, a_req_q.size};
    assign dmem_hwrite    = a_req_q.write;
    assign dmem_hwdata    = d_wdata_q;
    assign dmem_hburst    = HBURST_SINGLE;
    assign dmem_hmastlock = 1'b0;
    assign dmem_hprot     = HPROT_DATA;

    // The first ERROR cycle has hready low, so it naturally behaves as a wait state.
    assign done = d_valid_q && dmem_hready && !rst;

    assign resp0_valid = done && (d_owner_q == PORT0);
    assign resp1_valid = done && (d_owner_q == PORT1);
    assign resp0_err   = resp0_valid && dmem_hresp;
    assign resp1_err   = resp1_valid && dmem_hresp;
    assign resp0_rdata = d_write_q ? '0 : dmem_hrdata;
    assign resp1_rdata = d_write_q ? '0 : dmem_hrdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed vector table, hand-written stall/priority sequences,
// and randomized traffic against a transfer-queue reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic [1:0]  req0_size, req1_size;
    logic        req0_write, req1_write;
    logic [31:0] dmem_hrdata;
    logic        dmem_hready, dmem_hresp;

    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [31:0] resp0_rdata, resp1_rdata, dmem_haddr, dmem_hwdata;
    logic [2:0]  dmem_hburst, dmem_hsize;
    logic        dmem_hmastlock, dmem_hwrite;
    logic [3:0]  dmem_hprot;
    logic [1:0]  dmem_htrans;

    logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid, f_resp0_err, f_resp1_err;
    logic [31:0] f_resp0_rdata, f_resp1_rdata, f_haddr, f_hwdata;
    logic [2:0]  f_hburst, f_hsize;
    logic        f_hmastlock, f_hwrite;
    logic [3:0]  f_hprot;
    logic [1:0]  f_htrans;

    dmem_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size),
        .req0_write(req0_write), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size),
        .req1_write(req1_write), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .dmem_haddr(dmem_haddr), .dmem_hburst(dmem_hburst), .dmem_hmastlock(dmem_hmastlock),
        .dmem_hprot(dmem_hprot), .dmem_hsize(dmem_hsize), .dmem_htrans(dmem_htrans),
        .dmem_hwdata(dmem_hwdata), .dmem_hwrite(dmem_hwrite), .dmem_hrdata(dmem_hrdata),
        .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp)
    );

    dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size),
        .req0_write(req0_write), .req0_wdata(req0_wdata), .req0_ready(f_req0_ready),
        .resp0_valid(f_resp0_valid), .resp0_rdata(f_resp0_rdata), .resp0_err(f_resp0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size),
        .req1_write(req1_write), .req1_wdata(req1_wdata), .req1_ready(f_req1_ready),
        .resp1_valid(f_resp1_valid), .resp1_rdata(f_resp1_rdata), .resp1_err(f_resp1_err),
        .dmem_haddr(f_haddr), .dmem_hburst(f_hburst), .dmem_hmastlock(f_hmastlock),
        .dmem_hprot(f_hprot), .dmem_hsize(f_hsize), .dmem_htrans(f_htrans),
        .dmem_hwdata(f_hwdata), .dmem_hwrite(f_hwrite), .dmem_hrdata(dmem_hrdata),
        .dmem_hready(dmem_hready), .dmem_hresp(dmem_hresp)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, v0, v1, hready, hresp;
        logic [31:0] hrdata;
        logic        rdy0, rdy1, ns;
        logic [31:0] haddr;
        logic        r0, r1, e0, e1;
    } vec_t;

    typedef struct {
        bit          owner;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    task automatic fixed_fields();
        req0_addr = 32'h0000_0100; req0_size = 2'd2; req0_write = 1'b0; req0_wdata = '0;
        req1_addr = 32'h2000_0000; req1_size = 2'd2; req1_write = 1'b1; req1_wdata = 32'h1234_5678;
    endtask

    task automatic idle_cycle(input logic r);
        @(negedge clk);
        rst = r; req0_valid = 1'b0; req1_valid = 1'b0;
        dmem_hready = 1'b1; dmem_hresp = 1'b0; dmem_hrdata = '0;
    endtask

    vec_t  tbl[26];
    xfer_t q[$];
    bit    in_data;
    bit    last;
    logic  pv[2];
    xfer_t pr[2];

    initial begin
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        dmem_hready = 1'b1; dmem_hresp = 1'b0; dmem_hrdata = '0;
        fixed_fields();

        //           rst v0 v1 hr hrsp hrdata        rdy0 rdy1 ns haddr         r0 r1 e0 e1
        tbl[0]  = '{1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 32'h0,          1, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 1, 32'h100,        0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 1, 0, 32'hDEADBEEF,   0, 0, 0, 32'h0,          1, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 1, 0, 32'h0,          1, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[6]  = '{0, 1, 1, 1, 0, 32'h0,          0, 1, 1, 32'h100,        0, 0, 0, 0};
        tbl[7]  = '{0, 1, 1, 1, 0, 32'h11111111,   1, 0, 1, 32'h2000_0000,  1, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 1, 32'h100,        0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 1, 0, 32'h22222222,   0, 0, 0, 32'h0,          1, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 1, 0, 32'h0,          1, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 32'h0,          1, 0, 1, 32'h100,        0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 1, 32'h0,          0, 0, 1, 32'h100,        0, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 1, 1, 32'h33333333,   0, 0, 1, 32'h100,        1, 0, 1, 0};
        tbl[15] = '{0, 0, 0, 1, 0, 32'h44444444,   0, 0, 0, 32'h0,          1, 0, 0, 0};
        tbl[16] = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[17] = '{0, 0, 1, 1, 0, 32'h0,          0, 1, 0, 32'h0,          0, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 1, 32'h2000_0000,  0, 0, 0, 0};
        tbl[19] = '{1, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[20] = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[21] = '{0, 1, 1, 1, 0, 32'h0,          1, 0, 0, 32'h0,          0, 0, 0, 0};
        tbl[22] = '{0, 0, 1, 1, 0, 32'h0,          0, 1, 1, 32'h100,        0, 0, 0, 0};
        tbl[23] = '{0, 0, 0, 1, 0, 32'h55555555,   0, 0, 1, 32'h2000_0000,  1, 0, 0, 0};
        tbl[24] = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 1, 0, 0};
        tbl[25] = '{0, 0, 0, 1, 0, 32'h0,          0, 0, 0, 32'h0,          0, 0, 0, 0};

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
            dmem_hready = tbl[i].hready; dmem_hresp = tbl[i].hresp; dmem_hrdata = tbl[i].hrdata;
            #1;
            chk($sformatf("tbl%0d ready0", i), 32'(req0_ready), 32'(tbl[i].rdy0));
            chk($sformatf("tbl%0d ready1", i), 32'(req1_ready), 32'(tbl[i].rdy1));
            chk($sformatf("tbl%0d htrans", i), 32'(dmem_htrans), tbl[i].ns ? 32'h2 : 32'h0);
            if (tbl[i].ns) chk($sformatf("tbl%0d haddr", i), dmem_haddr, tbl[i].haddr);
            chk($sformatf("tbl%0d resp0_valid", i), 32'(resp0_valid), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d resp1_valid", i), 32'(resp1_valid), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d resp0_err", i), 32'(resp0_err), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d resp1_err", i), 32'(resp1_err), 32'(tbl[i].e1));
            if (tbl[i].r0) chk($sformatf("tbl%0d resp0_rdata", i), resp0_rdata, tbl[i].hrdata);
        end
        chk("hburst", 32'(dmem_hburst), 32'h0);
        chk("hprot", 32'(dmem_hprot), 32'h3);
        chk("hmastlock", 32'(dmem_hmastlock), 32'h0);

        // Sustained contention: round-robin alternates, fixed priority starves port 1.
        idle_cycle(1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; dmem_hready = 1'b1;
            #1;
            chk($sformatf("rr%0d ready0", i), 32'(req0_ready), 32'(i % 2 == 0));
            chk($sformatf("rr%0d ready1", i), 32'(req1_ready), 32'(i % 2 == 1));
            chk($sformatf("fp%0d ready0", i), 32'(f_req0_ready), 32'h1);
            chk($sformatf("fp%0d ready1", i), 32'(f_req1_ready), 32'h0);
            chk($sformatf("fp%0d resp1", i), 32'(f_resp1_valid), 32'h0);
            if (i >= 2) chk($sformatf("fp%0d resp0", i), 32'(f_resp0_valid), 32'h1);
        end

        // Store on port 1 then load on port 0, with three wait states in the store's data phase.
        idle_cycle(1'b1);
        @(negedge clk);
        rst = 1'b0; req1_valid = 1'b1; dmem_hready = 1'b1;
        #1 chk("stall c0 ready1", 32'(req1_ready), 32'h1);
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1;
        #1;
        chk("stall c1 ready0", 32'(req0_ready), 32'h1);
        chk("stall c1 haddr", dmem_haddr, 32'h2000_0000);
        chk("stall c1 hwrite", 32'(dmem_hwrite), 32'h1);
        chk("stall c1 hsize", 32'(dmem_hsize), 32'h2);
        for (int i = 2; i < 5; i++) begin
            @(negedge clk);
            req0_valid = 1'b1; dmem_hready = 1'b0;
            #1;
            chk($sformatf("stall c%0d htrans", i), 32'(dmem_htrans), 32'h2);
            chk($sformatf("stall c%0d haddr", i), dmem_haddr, 32'h100);
            chk($sformatf("stall c%0d hwrite", i), 32'(dmem_hwrite), 32'h0);
            chk($sformatf("stall c%0d hwdata", i), dmem_hwdata, 32'h1234_5678);
            chk($sformatf("stall c%0d ready0", i), 32'(req0_ready), 32'h0);
            chk($sformatf("stall c%0d resp", i), {30'h0, resp1_valid, resp0_valid}, 32'h0);
        end
        @(negedge clk);
        dmem_hready = 1'b1;
        #1;
        chk("stall c5 resp1", 32'(resp1_valid), 32'h1);
        chk("stall c5 resp0", 32'(resp0_valid), 32'h0);
        chk("stall c5 hwdata", dmem_hwdata, 32'h1234_5678);
        chk("stall c5 ready0", 32'(req0_ready), 32'h1);
        @(negedge clk);
        req0_valid = 1'b0; dmem_hrdata = 32'hCAFE_F00D;
        #1;
        chk("stall c6 resp0", 32'(resp0_valid), 32'h1);
        chk("stall c6 rdata", resp0_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        #1 chk("stall c7 resp0", 32'(resp0_valid), 32'h1);

        // Randomized traffic against the transfer-queue model.
        idle_cycle(1'b1);
        q.delete(); in_data = 0; last = 1; pv[0] = 0; pv[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit    ae, hr, g0, g1;
            int    ai;
            @(negedge clk);
            rst = ($urandom_range(0, 149) == 0);
            hr  = ($urandom_range(0, 3) != 0);
            dmem_hready = hr; dmem_hresp = ($urandom_range(0, 7) == 0); dmem_hrdata = $urandom;
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 2) != 0) begin
                    pv[p] = 1'b1;
                    pr[p].owner = p[0];
                    pr[p].addr  = $urandom;
                    pr[p].size  = 2'($urandom_range(0, 2));
                    pr[p].write = 1'($urandom);
                    pr[p].wdata = $urandom;
                end
            end
            req0_valid = pv[0]; req0_addr = pr[0].addr; req0_size = pr[0].size;
            req0_write = pr[0].write; req0_wdata = pr[0].wdata;
            req1_valid = pv[1]; req1_addr = pr[1].addr; req1_size = pr[1].size;
            req1_write = pr[1].write; req1_wdata = pr[1].wdata;
            #1;
            if (rst) begin
                chk("rnd rst ready", {30'h0, req1_ready, req0_ready}, 32'h0);
                chk("rnd rst htrans", 32'(dmem_htrans), 32'h0);
                chk("rnd rst resp", {28'h0, resp1_err, resp0_err, resp1_valid, resp0_valid}, 32'h0);
                q.delete(); in_data = 0; last = 1;
                continue;
            end
            ae = in_data ? (q.size() > 1) : (q.size() > 0);
            ai = in_data ? 1 : 0;
            chk("rnd htrans", 32'(dmem_htrans), ae ? 32'h2 : 32'h0);
            if (ae) begin
                chk("rnd haddr", dmem_haddr, q[ai].addr);
                chk("rnd hsize", 32'(dmem_hsize), 32'(q[ai].size));
                chk("rnd hwrite", 32'(dmem_hwrite), 32'(q[ai].write));
            end
            if (in_data && q[0].write) chk("rnd hwdata", dmem_hwdata, q[0].wdata);
            chk("rnd resp0_valid", 32'(resp0_valid), 32'(in_data && hr && q[0].owner == 0));
            chk("rnd resp1_valid", 32'(resp1_valid), 32'(in_data && hr && q[0].owner == 1));
            if (in_data && hr) begin
                chk("rnd resp_err", 32'(q[0].owner ? resp1_err : resp0_err), 32'(dmem_hresp));
                if (!q[0].write)
                    chk("rnd rdata", q[0].owner ? resp1_rdata : resp0_rdata, dmem_hrdata);
            end
            g0 = 0; g1 = 0;
            if (!ae || hr) begin
                if (pv[0] && pv[1]) begin
                    if (last == 0) g1 = 1; else g0 = 1;
                end else begin
                    g0 = pv[0]; g1 = pv[1];
                end
            end
            chk("rnd ready0", 32'(req0_ready), 32'(g0));
            chk("rnd ready1", 32'(req1_ready), 32'(g1));
            if (hr) begin
                if (in_data) void'(q.pop_front());
                in_data = (q.size() > 0);
            end
            if (g0) begin q.push_back(pr[0]); pv[0] = 0; last = 0; end
            if (g1) begin q.push_back(pr[1]); pv[1] = 0; last = 1; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single AHB-Lite data-memory master port between two load/store requesters, one per issue pipe of the dual-issue core. Sits between the per-pipe load-store units and the dmem_* bus.
- Requesters use a valid/ready handshake.
- The block registers the address phase and tracks the data phase, including wait states and error responses.
- It returns raw bus read data to the owning requester. Byte lane extraction stays with the requester.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins contention.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
reqN_valid  in  1  port N (N=0,1) request valid; held with fields stable until reqN_ready
reqN_addr  in  32  byte address; alignment is requester's responsibility
reqN_size  in  2  0=byte 1=half 2=word
reqN_write  in  1  1=store
reqN_wdata  in  32  store data, already lane-aligned
reqN_ready  out  1  request accepted this cycle
respN_valid  out  1  one-cycle pulse: port N transfer completed
respN_rdata  out  32  hrdata on completion cycle (loads); don't-care for stores
respN_err  out  1  qualifies respN_valid: bus returned ERROR
dmem_haddr, dmem_hburst, dmem_hmastlock, dmem_hprot, dmem_hsize, dmem_htrans, dmem_hwdata, dmem_hwrite  out  32/3/1/4/3/2/32/1  AHB-Lite master outputs
dmem_hrdata  in  32; dmem_hready  in  1; dmem_hresp  in  1  AHB-Lite responses

Behaviour:
- **A-register** (address phase): a_valid, owner, addr, size, write, wdata.
- **D-register** (data phase): d_valid, owner, write, wdata.
- **Slot free:** a_free = !a_valid || dmem_hready.
- **Grant:**
  - Only when a_free. Exactly one reqN_ready is high, and only if that port is valid.
  - Contention: FIXED_PRIO=0 grants the port not granted last, and updates last_grant on each grant. FIXED_PRIO=1 grants port 0.
- **Grant cycle:** the A-register loads the granted request. If nothing is granted and a_free, a_valid clears.
- **Phase advance:** when dmem_hready=1, A moves to D: d_valid <= a_valid plus owner/write/wdata. When dmem_hready=0, A and D hold.
- **Bus outputs:**
  - dmem_htrans = a_valid ? NONSEQ : IDLE
  - dmem_haddr, dmem_hwrite and dmem_hsize={1'b0,size} come from the A-register.
  - dmem_hwdata comes from the D-register wdata.
  - dmem_hburst=SINGLE, dmem_hmastlock=0, dmem_hprot=4'b0011.
  - Address-phase signals stay stable while hready=0.
- **Completion:** d_valid && dmem_hready gives resp[owner]_valid=1 with rdata=dmem_hrdata and err=dmem_hresp, combinationally in that cycle. The other port's resp_valid=0.
- **Error:** the first ERROR cycle (hresp=1, hready=0) is a wait state. The already-issued A-phase is not cancelled; it proceeds normally.
- **Latency:** accepted in cycle N → NONSEQ in N+1 → resp earliest N+2. Sustained throughput is one transfer per cycle with zero wait states.
- **Reset:**
  - a_valid=0, d_valid=0, last_grant=1 (port 0 first).
  - Reset dominates a concurrent grant or completion.
  - Outputs during and after reset: htrans=IDLE, ready=0, respN_valid=0, respN_err=0.
  - Reset mid-transfer drops the in-flight transfer without any response.
- **Same-cycle events:** a new grant, an A→D advance and a D completion may all occur in one cycle.
- **Unused fields:** A/D data fields need no reset; valid bits gate them.

Decomposition:
- srv_defs gets:
  - dmem_req_t (addr, size, write, wdata)
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HBURST_SINGLE=3'b000, HPROT_DATA=4'b0011
- Sub-module rr_arb2: 2-way round-robin/fixed-priority pick. Inputs: req[1:0], en, FIXED_PRIO. Outputs: gnt[1:0], and it holds last_grant.

Test Plan:
- Port 0 load at 0x100, hready=1 throughout → req0_ready cycle 0; htrans=2'b10, haddr=0x100, hsize=2 in cycle 1; resp0_valid with rdata=hrdata=0xDEADBEEF in cycle 2; resp1_valid stays 0.
- Both ports valid every cycle from reset, FIXED_PRIO=0 → grants alternate 0,1,0,1; haddr alternates per cycle; each resp routed to the correct port in order. With FIXED_PRIO=1, port 0 is starved-free and port 1 waits.
- Port 1 store 0x2000_0000 wdata=0x1234_5678, followed by a port 0 load, hready=0 for 3 cycles after the store's address phase → haddr/htrans/hwrite stay frozen; no req accepted; hwdata=0x1234_5678 throughout the data phase; resp1 fires when hready rises.
- ERROR response: hresp=1,hready=0 then hresp=1,hready=1 → resp0_valid=1, resp0_err=1 on the second cycle only; the pipelined next transfer still completes normally.
- Assert rst while a transfer is in the D phase → next cycle htrans=IDLE, no respN_valid. After release, first contention grants port 0.
